rx_8b10b_sync_ctrl: RTL
=======================

// Module: rx_8b10b_sync_ctrl
// PURPOSE
//  Receive-side link controller wrapped around the 8b/10b decoder. It owns the running-disparity
//  register fed back to the decoder's dispin, and runs a comma-based word-sync state machine
//  (simplified 802.3 cl.36) over the decoder's code/disparity error flags. It gates decoded
//  bytes to the SERDES RX framer and keeps saturating error counters for the status registers.
// PARAMETERS
//  COMMA       9'h1BC  {k,data} word that counts as a comma (K28.5)
//  ACQ_COMMAS  3       clean commas needed to declare sync (2..7)
//  GOOD_RECOV  4       consecutive clean words that cancel one bad-word strike (1..15)
//  CNT_W       16      width of each error counter
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active high
//  dec_valid     in   1      decoder outputs below are valid this cycle
//  dec_data      in   9      {k, byte[7:0]} from decoder
//  dec_dispout   in   1      decoder running disparity out (1 = positive)
//  dec_code_err  in   1      decoder code error
//  dec_disp_err  in   1      decoder disparity error
//  rd            out  1      registered running disparity, drives decoder dispin
//  rx_data       out  8      decoded byte
//  rx_k          out  1      control-character flag
//  rx_valid      out  1      rx_data/rx_k valid (one-cycle strobe)
//  sync          out  1      link word-synchronised
//  clr_cnt       in   1      clear both error counters
//  code_err_cnt  out  CNT_W  saturating count of code errors
//  disp_err_cnt  out  CNT_W  saturating count of disparity errors
// BEHAVIOUR
//  - Reset: every output is 0, state LOS, comma count and strike/good counters are 0. This also
//    applies when rst is asserted mid-frame; it takes effect at the next clk edge.
//  - bad = dec_valid & (dec_code_err | dec_disp_err); comma = dec_valid & ~bad & dec_data==COMMA.
//  - Every input is ignored on cycles where dec_valid = 0. State, rd and the counters hold.
//  - rd <= dec_dispout on each dec_valid, in every state, even when the word is bad.
//  - States:
//      LOS: comma -> CD with ccnt=1.
//      CD: bad -> LOS. comma -> ccnt+1; reaching ACQ_COMMAS -> SYNC with strikes=0, good=0.
//          Any other clean word -> stay in CD.
//      SYNC: bad -> strikes+1, good=0; strikes reaching 4 -> LOS.
//            Clean word with strikes>0 -> good+1; good reaching GOOD_RECOV -> strikes-1, good=0.
//  - sync = 1 exactly while state == SYNC (registered). It rises on the edge after the
//    ACQ_COMMA-th comma is sampled and falls on the edge after the 4th strike.
//  - rx_valid, rx_data and rx_k are registered with 1-cycle latency:
//      rx_valid <= dec_valid & ~dec_code_err & (state==SYNC), using the state before update.
//      rx_data/rx_k load only when rx_valid will be set and hold otherwise.
//    Words with a disparity error only are still delivered.
//  - Counters: +1 per dec_valid cycle with the matching flag. They saturate at all-ones.
//    clr_cnt wins over a simultaneous increment (result 0 next cycle).
// TESTING
//  1. rst, then 3 valid COMMA words back-to-back: sync=0 after words 1-2; sync=1 one cycle after
//     word 3; rx_valid stays 0 for all three.
//  2. In sync, feed 0x55 (k=0), then 4 words with dec_code_err=1: rx_valid=1 with rx_data=8'h55;
//     sync drops one cycle after the 4th error; code_err_cnt=4.
//  3. In sync, 1 error then 4 clean words, then 3 errors: sync stays 1 throughout (strike
//     cancelled); a 4th error then drops sync.
//  4. CNT_W=3, 9 disp_err words: disp_err_cnt sticks at 7. Then clr_cnt together with another
//     disp_err: count reads 0.
//  5. Alternating dec_dispout 1,0,1 with dec_valid gaps: rd follows dec_dispout only on valid
//     cycles and holds across gaps.
//  6. CD state, 1 comma then a code error: return to LOS. Then rst asserted in SYNC: all outputs
//     0 on the next cycle.

Source files
------------

// File: rtl/rx_8b10b_sync_ctrl.sv
// Receive link controller: running-disparity feedback, comma word-sync FSM, gated byte output, error counters.
// Latency: 1 cycle from a valid decoder word to rd/rx_*/sync/counter updates.
// Backpressure: none; words are consumed on every dec_valid cycle and held state is frozen otherwise.
module rx_8b10b_sync_ctrl #(
  parameter logic [8:0] COMMA      = 9'h1BC,
  parameter int         ACQ_COMMAS = 3,
  parameter int         GOOD_RECOV = 4,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [8:0]       dec_data,
  input  logic             dec_dispout,
  input  logic             dec_code_err,
  input  logic             dec_disp_err,
  output logic             rd,
  output logic [7:0]       rx_data,
  output logic             rx_k,
  output logic             rx_valid,
  output logic             sync,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] code_err_cnt,
  output logic [CNT_W-1:0] disp_err_cnt
);

  typedef enum logic [1:0] {LOS, CD, SYNC} state_t;

  localparam logic [2:0] ACQ_N  = 3'(ACQ_COMMAS);
  localparam logic [3:0] GOOD_N = 4'(GOOD_RECOV);

  state_t     state;
  logic [2:0] ccnt;
  logic [2:0] strikes;
  logic [3:0] good;
  logic       bad;
  logic       comma;
  logic       deliver;

  assign bad     = dec_valid & (dec_code_err | dec_disp_err);
  assign comma   = dec_valid & ~bad & (dec_data == COMMA);
  // Decision uses the state before this cycle's update, so the word that
  // completes acquisition is itself not delivered.
  assign deliver = dec_valid & ~dec_code_err & (state == SYNC);

  // Word-sync FSM: acquire on consecutive clean commas, lose after four
  // net strikes; runs of clean words in sync forgive one strike each.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOS;
      sync    <= 1'b0;
      ccnt    <= 3'd0;
      strikes <= 3'd0;
      good    <= 4'd0;
    end else if (dec_valid) begin
      case (state)
        LOS: begin
          if (comma) begin
            state <= CD;
            ccnt  <= 3'd1;
          end
        end
        CD: begin
          if (bad) begin
            state <= LOS;
            ccnt  <= 3'd0;
          end else if (comma) begin
            if (ccnt + 3'd1 == ACQ_N) begin
              state   <= SYNC;
              sync    <= 1'b1;
              ccnt    <= 3'd0;
              strikes <= 3'd0;
              good    <= 4'd0;
            end else begin
              ccnt <= ccnt + 3'd1;
            end
          end
        end
        SYNC: begin
          if (bad) begin
            good <= 4'd0;
            if (strikes == 3'd3) begin
              state   <= LOS;
              sync    <= 1'b0;
              strikes <= 3'd0;
            end else begin
              strikes <= strikes + 3'd1;
            end
          end else if (strikes != 3'd0) begin
            if (good + 4'd1 == GOOD_N) begin
              strikes <= strikes - 3'd1;
              good    <= 4'd0;
            end else begin
              good <= good + 4'd1;
            end
          end
        end
        default: begin
          state <= LOS;
          sync  <= 1'b0;
        end
      endcase
    end
  end

  // Disparity feedback and output byte gating; rd tracks every valid word,
  // including bad ones, so the decoder stays aligned with the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd       <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'd0;
      rx_k     <= 1'b0;
    end else begin
      rx_valid <= deliver;
      if (deliver) begin
        rx_data <= dec_data[7:0];
        rx_k    <= dec_data[8];
      end
      if (dec_valid) begin
        rd <= dec_dispout;
      end
    end
  end

  // Saturating error counters; a clear request beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_err_cnt <= '0;
      disp_err_cnt <= '0;
    end else if (clr_cnt) begin
      code_err_cnt <= '0;
      disp_err_cnt <= '0;
    end else begin
      if (dec_valid & dec_code_err & ~&code_err_cnt) begin
        code_err_cnt <= code_err_cnt + CNT_W'(1);
      end
      if (dec_valid & dec_disp_err & ~&disp_err_cnt) begin
        disp_err_cnt <= disp_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
